apb_reg_slave: RTL
==================

# apb_reg_slave

APB responder that terminates the 8-bit APB bus driven by `apb_converter` and holds a small register file. It decodes `paddr` against a fixed window, inserts a programmable number of wait states via `pready`, commits writes, and returns read data. Unmapped reads return 8'hFF and unmapped writes are dropped. It is the synthesizable replacement for the bench-only slave model.

## Interface
- `NUM_REGS`, default 16: register count, power of two, at most 16.
- `BASE_ADDR`, default 8'hC0: window base, aligned to `NUM_REGS`.
- `WAIT_CYCLES`, default 2: wait states per access, range 0–15.
- `pclk`, in, 1: clock; all logic on the rising edge.
- `presetn`, in, 1: reset, asynchronous, active-low.
- `paddr`, in, 8: transfer address.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `psel`, in, 1: slave select.
- `penable`, in, 1: access-phase marker.
- `pwdata`, in, 8: write data.
- `prdata`, out, 8: read data.
- `pready`, out, 1: transfer completes this cycle.
- `pslverr`, out, 1: error response; present only with `APB_SLAVE_PSLVERR_EN`.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE→SETUP on `psel && !penable`.
- SETUP→ACCESS unconditionally. The wait counter `wcnt` is loaded with `WAIT_CYCLES` in the SETUP cycle.
- ACCESS, `wcnt != 0`: `pready` = 0 and `wcnt` decrements.
- ACCESS, `wcnt == 0`: `pready` = 1. This is the completing cycle.
- Completion exit:
  - to SETUP if `psel && !penable` is seen in the following cycle (back-to-back);
  - otherwise to IDLE.
- Decode: hit = `paddr[7:log2(NUM_REGS)] == BASE_ADDR[7:log2(NUM_REGS)]`. Index = low `log2(NUM_REGS)` bits.
- Write commit: at the rising edge where `psel && penable && pready && pwrite && hit`, `regs[index] <= pwdata`. Unmapped writes change nothing.
- Read data:
  - `prdata` = `regs[index]` when `psel && penable && pready && !pwrite && hit`;
  - 8'hFF on an unmapped read completion;
  - 8'h00 at all other times.
- `paddr`, `pwrite` and `pwdata` are used as presented in the completing cycle. The master keeps them stable per APB.
- `psel` deasserted while in SETUP or ACCESS (protocol violation): return to IDLE, no write, `wcnt` cleared.
- `penable` high while in IDLE with no SETUP seen: ignored, stay IDLE, `pready` = 0.

## Timing
- Reset values: state IDLE, `wcnt` 0, all `regs` 8'h00, `pready` 0, `prdata` 8'h00, `pslverr` 0.
- Reset mid-transfer aborts immediately. No commit occurs, and registers clear.
- `pready`, `prdata` and `pslverr` are combinational from registered state, `wcnt` and the bus inputs. There is no extra output register.
- Transfer length is SETUP (1 cycle) plus ACCESS (`WAIT_CYCLES` + 1 cycles).
  - `WAIT_CYCLES` = 0 gives the minimum 2-cycle transfer.
  - Default 2 gives 4 cycles.
- Write data is visible to a read whose completion falls at or after the cycle following the write's completion.
- `pready` is 0 in IDLE, in SETUP, and in ACCESS while `wcnt != 0`.

## Configuration
- `APB_SLAVE_PSLVERR_EN` defined:
  - `pslverr` port exists;
  - `pslverr` = 1 only in the completing cycle of an unmapped access, read or write;
  - unmapped read still returns 8'hFF.
- Not defined:
  - no `pslverr` port;
  - unmapped accesses complete silently with the same data and drop behaviour.

## Structure
- Package `apb_slave_pkg`:
  - `APB_ADDR_W` = 8, `APB_DATA_W` = 8;
  - `UNMAPPED_RDATA` = 8'hFF;
  - state enum `apb_slv_state_t` {IDLE, SETUP, ACCESS}.
- Sub-module `apb_slave_regfile`:
  - holds the `NUM_REGS` x 8 array with asynchronous clear;
  - one write port (`we`, `waddr`, `wdata`) and one combinational read port.
- The top level holds the FSM, wait counter, decode and response muxing.

## Test plan
- Reset: hold `presetn` = 0 for 10 cycles, then read 0xC3 → `prdata` 8'h00, `pready` high for exactly 1 cycle after 2 wait cycles.
- Mapped write then read: write 0xCC ← 8'hAC, then read 0xCC → 8'hAC; each transfer takes 4 cycles with the default `WAIT_CYCLES`.
- Unmapped accesses:
  - write 0xF5 ← 8'h50 → no register changes (readback of 0xC5 still 8'h00);
  - read 0x55 → `prdata` 8'hFF;
  - with `APB_SLAVE_PSLVERR_EN`, `pslverr` = 1 in the completing cycle of both.
- Back-to-back: write 0xC1 ← 8'h11 then write 0xC2 ← 8'h22 with no IDLE gap → both commit; readback 8'h11 and 8'h22.
- `WAIT_CYCLES` = 0 build: write 0xC0 ← 8'h5A → `pready` high in the first ACCESS cycle; transfer takes 2 cycles.
- Abort cases:
  - drop `presetn` during the ACCESS wait of a write 0xC7 ← 8'h77 → readback 8'h00;
  - drop `psel` during the ACCESS wait → FSM returns to IDLE, no commit.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared constants and types for the APB register slave.
package apb_slave_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    localparam logic [APB_DATA_W-1:0] UNMAPPED_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// Register array for the APB slave: one synchronous write port, one combinational read port.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    // NOTE: the array sits on the async reset like any other flop, so a reset mid-transfer leaves every register at 8'h00.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/apb_reg_slave.sv
// APB responder with a small register file and programmable wait states.
// Optional: define APB_SLAVE_PSLVERR_EN to add the pslverr port for unmapped accesses.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 8'hC0,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready
`ifdef APB_SLAVE_PSLVERR_EN
    ,
    output logic                  pslverr
`endif
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_slv_state_t        state_q, state_d, phase;
    logic [3:0]            wcnt_q, wcnt_d;
    logic                  hit;
    logic                  xfer_done;
    logic                  reg_we;
    logic [APB_DATA_W-1:0] reg_rdata;

    // The SETUP cycle is the bus setup phase itself, so it is decoded from the
    // inputs rather than registered; only ACCESS needs to be remembered.
    always_comb begin
        // NOTE: default first so every path assigns phase and no latch is inferred.
        phase = IDLE;
        if (state_q == ACCESS) begin
            phase = ACCESS;
        end else if (psel && !penable) begin
            phase = SETUP;
        end
    end

    assign hit       = (paddr[APB_ADDR_W-1:IDX_W] == BASE_ADDR[APB_ADDR_W-1:IDX_W]);
    assign pready    = (phase == ACCESS) && psel && (wcnt_q == 4'd0);
    assign xfer_done = psel && penable && pready;
    assign reg_we    = xfer_done && pwrite && hit;

    always_comb begin
        prdata = '0;
        if (xfer_done && !pwrite) begin
            prdata = hit ? reg_rdata : UNMAPPED_RDATA;
        end
    end

`ifdef APB_SLAVE_PSLVERR_EN
    assign pslverr = xfer_done && !hit;
`endif

    // Completion and psel aborts both fall back to IDLE with wcnt cleared.
    always_comb begin
        state_d = IDLE;
        wcnt_d  = '0;
        case (phase)
            SETUP: begin
                state_d = ACCESS;
                wcnt_d  = 4'(WAIT_CYCLES);
            end
            ACCESS: begin
                if (psel && (wcnt_q != 4'd0)) begin
                    state_d = ACCESS;
                    wcnt_d  = wcnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    apb_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (reg_we),
        .waddr   (paddr[IDX_W-1:0]),
        .wdata   (pwdata),
        .raddr   (paddr[IDX_W-1:0]),
        .rdata   (reg_rdata)
    );

endmodule
